// File: rtl/lsu_pkg.sv
// Shared types for the MEM-stage load/store unit: FSM state encoding,
// funct3 access-size constants and a size decode helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Undefined encodings (011, 110, 111) behave as full-word accesses.
  function automatic logic [1:0] f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      F3_W:        return SZ_W;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store byte enables / lane replication and
// load lane extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_signed;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
  end

  // Halfword lane uses only a[1]; a stray a[0] is truncated.
  assign w_half   = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign w_signed = ~i_funct3[2];

  always_comb begin
    o_be        = 4'b1111;
    o_wdata     = i_store_data;
    o_load_data = i_rdata;
    case (f3_size(i_funct3))
      SZ_B: begin
        o_be        = 4'b0001 << i_addr_lo;
        o_wdata     = {4{i_store_data[7:0]}};
        o_load_data = {{24{w_signed & w_byte[7]}}, w_byte};
      end
      SZ_H: begin
        o_be        = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata     = {2{i_store_data[15:0]}};
        o_load_data = {{16{w_signed & w_half[15]}}, w_half};
      end
      default: begin
        o_be        = 4'b1111;
        o_wdata     = i_store_data;
        o_load_data = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/gnt/rvalid bus FSM with pipeline stall.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of truncating.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Mem_Read_In,
  input  logic              Mem_Write_In,
  input  logic [2:0]        Funct3_In,
  input  logic [ADDR_W-1:0] ALU_Result_In,
  input  logic [DATA_W-1:0] Write_Data_In,
  output logic              Stall_Out,
  output logic [DATA_W-1:0] Load_Data_Out,
  output logic              Load_Valid_Out,
  output logic              Misalign_Out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata
);

  lsu_state_e        r_state;
  logic              r_load_valid;
  logic              r_misalign;
  logic [DATA_W-1:0] r_load_data;

  logic              w_access;
  logic              w_is_load;
  logic              w_misalign;
  logic              w_in_req;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_load_ext;

  // A simultaneous read and write request is serviced as a load.
  assign w_access  = Mem_Read_In | Mem_Write_In;
  assign w_is_load = Mem_Read_In;
  assign w_in_req  = (r_state == REQ);

`ifdef LSU_MISALIGN_TRAP_EN
  logic [1:0] w_size;
  assign w_size     = f3_size(Funct3_In);
  assign w_misalign = ((w_size == SZ_H) && ALU_Result_In[0]) ||
                      ((w_size == SZ_W) && (ALU_Result_In[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  lsu_align u_align (
    .i_funct3     (Funct3_In),
    .i_addr_lo    (ALU_Result_In[1:0]),
    .i_store_data (Write_Data_In),
    .i_rdata      (dmem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_ext)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_load_valid <= 1'b0;
      r_misalign   <= 1'b0;
      r_load_data  <= '0;
    end else begin
      r_load_valid <= 1'b0;
      r_misalign   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_access) begin
            if (w_misalign) begin
              r_state    <= DONE;
              r_misalign <= 1'b1;
            end else begin
              r_state <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            if (!w_is_load) begin
              r_state <= DONE;
            end else if (dmem_rvalid) begin
              r_load_data  <= w_load_ext;
              r_load_valid <= 1'b1;
              r_state      <= DONE;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            r_load_data  <= w_load_ext;
            r_load_valid <= 1'b1;
            r_state      <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stall drops in DONE so EX/MEM advances at the end of that cycle.
  assign Stall_Out = ((r_state == IDLE) && w_access) || (r_state == REQ) || (r_state == WAIT);

  assign Load_Data_Out  = r_load_data;
  assign Load_Valid_Out = r_load_valid;
  assign Misalign_Out   = r_misalign;

  // Bus fields are only driven while a request is outstanding.
  assign dmem_req   = w_in_req;
  assign dmem_we    = w_in_req & ~w_is_load;
  assign dmem_addr  = w_in_req ? {ALU_Result_In[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_be    = w_in_req ? w_be : 4'b0000;
  assign dmem_wdata = w_in_req ? w_wdata : '0;

endmodule
